// File: rtl/arith_pkg.sv
// Shared constants for the sequential arithmetic unit: operation modes and FSM state encoding.
// The ARITH_DIV_EN macro decides whether divide is an iterative operation.
package arith_pkg;

    localparam logic [1:0] ARITH_ADD = 2'b00;
    localparam logic [1:0] ARITH_SUB = 2'b01;
    localparam logic [1:0] ARITH_MUL = 2'b10;
    localparam logic [1:0] ARITH_DIV = 2'b11;

    typedef logic [1:0] arith_state_t;

    localparam arith_state_t ST_IDLE = 2'd0;
    localparam arith_state_t ST_CALC = 2'd1;
    localparam arith_state_t ST_ITER = 2'd2;
    localparam arith_state_t ST_DONE = 2'd3;

    // Modes that run through the multi-cycle shift datapath.
    function automatic logic is_iter_mode(input logic [1:0] mode);
`ifdef ARITH_DIV_EN
        return (mode == ARITH_MUL) || (mode == ARITH_DIV);
`else
        return (mode == ARITH_MUL);
`endif
    endfunction

endpackage

// File: rtl/arith_iter_core.sv
// Iterative shift-add multiplier and restoring divider, WIDTH steps per operation.
// The divider datapath exists only when ARITH_DIV_EN is defined.
module arith_iter_core
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_prod
`ifdef ARITH_DIV_EN
    ,
    output logic [WIDTH-1:0]     o_quo,
    output logic [WIDTH-1:0]     o_rem
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic                r_busy;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_acc;
    logic [2*WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  w_acc_nxt;

    assign o_done    = r_busy && (r_cnt == LAST);
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Results are the next-state values so the top can capture them on the done edge.
    assign o_prod    = w_acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (r_busy) begin
            r_busy   <= !o_done;
            r_cnt    <= r_cnt + CW'(1);
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

`ifdef ARITH_DIV_EN
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;

    // A zero divisor always "fits", which yields an all-ones quotient and remainder = A.
    assign w_trial   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_trial >= {1'b0, r_dvs});
    assign w_rem_nxt = WIDTH'(w_ge ? (w_trial - {1'b0, r_dvs}) : w_trial);
    assign o_quo     = {r_quo[WIDTH-2:0], w_ge};
    assign o_rem     = w_rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (i_start) begin
            r_quo <= i_a;
            r_rem <= '0;
            r_dvs <= i_b;
        end else if (r_busy) begin
            r_quo <= o_quo;
            r_rem <= w_rem_nxt;
        end
    end
`endif

endmodule

// File: rtl/arith_seq_unit.sv
// Handshaked multi-mode arithmetic unit: one-cycle add/sub, iterative mul (and div when
// ARITH_DIV_EN is defined); each result is held until the consumer takes it.
module arith_seq_unit
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [1:0]           M,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   S,
    output logic                 Cout,
    output logic [WIDTH-1:0]     Sr,
    output logic                 err
);

    arith_state_t        r_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [1:0]          r_m;
    logic                r_out_valid;
    logic [2*WIDTH-1:0]  r_s;
    logic                r_cout;
    logic [WIDTH-1:0]    r_sr;
    logic                r_err;

    logic                w_accept;
    logic                w_start;
    logic                w_done;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [2*WIDTH-1:0]  w_calc_s;
    logic                w_calc_cout;
    logic                w_calc_err;
    logic [2*WIDTH-1:0]  w_iter_s;
    logic [WIDTH-1:0]    w_iter_sr;
    logic                w_iter_err;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    // The core samples the live operand inputs on the accept edge.
    assign w_start  = w_accept && is_iter_mode(M);

`ifdef ARITH_DIV_EN
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
`endif

    arith_iter_core #(
        .WIDTH (WIDTH)
    ) u_iter_core (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_a     (A),
        .i_b     (B),
        .o_done  (w_done),
        .o_prod  (w_prod)
`ifdef ARITH_DIV_EN
        ,
        .o_quo   (w_quo),
        .o_rem   (w_rem)
`endif
    );

    // The extra MSB of the difference is the borrow.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_calc_s    = '0;
        w_calc_cout = 1'b0;
        w_calc_err  = 1'b0;
        case (r_m)
            ARITH_ADD: begin
                w_calc_s    = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
                w_calc_cout = w_sum[WIDTH];
            end
            ARITH_SUB: begin
                w_calc_s    = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                w_calc_cout = w_diff[WIDTH];
            end
            default: w_calc_err = 1'b1;
        endcase
    end

    always_comb begin
        w_iter_s   = w_prod;
        w_iter_sr  = '0;
        w_iter_err = 1'b0;
`ifdef ARITH_DIV_EN
        if (r_m == ARITH_DIV) begin
            w_iter_s   = {{WIDTH{1'b0}}, w_quo};
            w_iter_sr  = w_rem;
            w_iter_err = (r_b == '0);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_m         <= '0;
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_sr        <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_m     <= M;
                        r_state <= is_iter_mode(M) ? ST_ITER : ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_s         <= w_calc_s;
                    r_cout      <= w_calc_cout;
                    r_sr        <= '0;
                    r_err       <= w_calc_err;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_ITER: begin
                    if (w_done) begin
                        r_s         <= w_iter_s;
                        r_cout      <= 1'b0;
                        r_sr        <= w_iter_sr;
                        r_err       <= w_iter_err;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign S         = r_s;
    assign Cout      = r_cout;
    assign Sr        = r_sr;
    assign err       = r_err;

endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed and exhaustive checks of arith_seq_unit at WIDTH=8 and WIDTH=2 with a result scoreboard.
// Expectations follow ARITH_DIV_EN the same way the design build does.
module tb_arith_seq_unit;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic [31:0] sr;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, c8, e8;
    logic [7:0]  a8 = '0, b8 = '0, sr8;
    logic [1:0]  m8 = '0;
    logic [15:0] s8;

    logic        iv2 = 1'b0, ir2, ov2, or2 = 1'b0, c2, e2;
    logic [1:0]  a2 = '0, b2 = '0, sr2;
    logic [1:0]  m2 = '0;
    logic [3:0]  s2;

    logic        cur = 1'b0;
    logic        mov, mir, mc, me;
    logic [31:0] ms, msr;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    arith_seq_unit #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .A         (a8),
        .B         (b8),
        .M         (m8),
        .out_valid (ov8),
        .out_ready (or8),
        .S         (s8),
        .Cout      (c8),
        .Sr        (sr8),
        .err       (e8)
    );

    arith_seq_unit #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .A         (a2),
        .B         (b2),
        .M         (m2),
        .out_valid (ov2),
        .out_ready (or2),
        .S         (s2),
        .Cout      (c2),
        .Sr        (sr2),
        .err       (e2)
    );

    always_comb begin
        mov = cur ? ov2 : ov8;
        mir = cur ? ir2 : ir8;
        mc  = cur ? c2 : c8;
        me  = cur ? e2 : e8;
        ms  = cur ? 32'(s2) : 32'(s8);
        msr = cur ? 32'(sr2) : 32'(sr8);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input int a, input int b, input int m);
        exp_t e;
        int   mask;
        mask   = (1 << w) - 1;
        e.s    = 0;
        e.cout = 1'b0;
        e.sr   = 0;
        e.err  = 1'b0;
        case (m)
            0: begin
                e.s    = (a + b) & mask;
                e.cout = ((a + b) > mask);
            end
            1: begin
                e.s    = (a - b) & mask;
                e.cout = (a < b);
            end
            2: e.s = a * b;
            default: begin
`ifdef ARITH_DIV_EN
                if (b == 0) begin
                    e.s   = mask;
                    e.sr  = a;
                    e.err = 1'b1;
                end else begin
                    e.s  = a / b;
                    e.sr = a % b;
                end
`else
                e.err = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    function automatic int exp_lat(input int w, input int m);
`ifdef ARITH_DIV_EN
        return (m >= 2) ? w + 1 : 2;
`else
        return (m == 2) ? w + 1 : 2;
`endif
    endfunction

    task automatic drive(input logic v, input int a, input int b, input int m);
        if (cur) begin
            iv2 = v; a2 = 2'(a); b2 = 2'(b); m2 = 2'(m);
        end else begin
            iv8 = v; a8 = 8'(a); b8 = 8'(b); m8 = 2'(m);
        end
    endtask

    task automatic set_ordy(input logic r);
        if (cur) or2 = r;
        else     or8 = r;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/in_ready"}, 32'(mir), 1);
        check({tag, "/out_valid"}, 32'(mov), 0);
        check({tag, "/S"}, ms, 0);
        check({tag, "/Cout"}, 32'(mc), 0);
        check({tag, "/Sr"}, msr, 0);
        check({tag, "/err"}, 32'(me), 0);
    endtask

    // One full transaction: accept, latency, stall stability, scoreboard compare, handshake.
    task automatic run_op(input string tag, input int a, input int b, input int m,
                          input exp_t e, input int lat_exp, input int stall);
        int          lat;
        int          busy_ready;
        logic [31:0] s_hold;
        logic        err_hold;
        exp_t        got;
        check({tag, "/idle_ready"}, 32'(mir), 1);
        sb.push_back(e);
        drive(1'b1, a, b, m);
        @(posedge clk); #1;
        lat = 1;
        busy_ready = 0;
        // Scramble operands after accept; the result must not depend on them.
        drive(1'b0, a ^ 165, b ^ 60, m ^ 1);
        while (!mov && lat < 40) begin
            if (mir) busy_ready++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, lat, lat_exp);
        check({tag, "/busy_in_ready"}, busy_ready, 0);
        s_hold   = ms;
        err_hold = me;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "/stall_valid"}, 32'(mov), 1);
            check({tag, "/stall_S"}, ms, s_hold);
            check({tag, "/stall_err"}, 32'(me), 32'(err_hold));
        end
        check({tag, "/sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, "/S"}, ms, got.s);
            check({tag, "/Cout"}, 32'(mc), 32'(got.cout));
            check({tag, "/Sr"}, msr, got.sr);
            check({tag, "/err"}, 32'(me), 32'(got.err));
        end
        set_ordy(1'b1);
        @(posedge clk); #1;
        set_ordy(1'b0);
        check({tag, "/consumed_valid"}, 32'(mov), 0);
        check({tag, "/consumed_ready"}, 32'(mir), 1);
    endtask

    function automatic exp_t mk(input int s, input logic c, input int sr, input logic e);
        exp_t x;
        x.s = s; x.cout = c; x.sr = sr; x.err = e;
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int quiet_valid;

        // Reset held for three cycles; both instances must come up idle and zeroed.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cur = 1'b0; #1;
        check_reset_state("rst8");
        cur = 1'b1; #1;
        check_reset_state("rst2");

        cur = 1'b0; #1;
        run_op("add_200_100", 200, 100, 0, mk(44, 1'b1, 0, 1'b0), 2, 2);

        // Abort a multiply in the middle of its iterations.
        drive(1'b1, 255, 255, 2);
        @(posedge clk); #1;
        drive(1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("midop_rst");
        quiet_valid = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (mov) quiet_valid++;
        end
        check("midop_no_emit", quiet_valid, 0);

        run_op("sub_5_9", 5, 9, 1, mk(252, 1'b1, 0, 1'b0), 2, 0);
        run_op("sub_9_5", 9, 5, 1, mk(4, 1'b0, 0, 1'b0), 2, 1);
        run_op("add_255_1", 255, 1, 0, mk(0, 1'b1, 0, 1'b0), 2, 0);
        run_op("mul_255_255", 255, 255, 2, mk(65025, 1'b0, 0, 1'b0), 9, 3);
        run_op("mul_0_200", 0, 200, 2, mk(0, 1'b0, 0, 1'b0), 9, 0);
        run_op("mul_13_11", 13, 11, 2, mk(143, 1'b0, 0, 1'b0), 9, 0);
`ifdef ARITH_DIV_EN
        run_op("div_100_7", 100, 7, 3, mk(14, 1'b0, 2, 1'b0), 9, 1);
        run_op("div_37_0", 37, 0, 3, mk(255, 1'b0, 37, 1'b1), 9, 2);
`else
        run_op("div_100_7", 100, 7, 3, mk(0, 1'b0, 0, 1'b1), 2, 1);
        run_op("div_37_0", 37, 0, 3, mk(0, 1'b0, 0, 1'b1), 2, 2);
`endif
        run_op("add_after_div", 17, 3, 0, mk(20, 1'b0, 0, 1'b0), 2, 0);

        // WIDTH=2 exhaustive sweep with random consumer stalls.
        cur = 1'b1; #1;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int m = 0; m < 4; m++) begin
                    run_op($sformatf("w2_a%0d_b%0d_m%0d", a, b, m), a, b, m,
                           model(2, a, b, m), exp_lat(2, m), int'($urandom_range(0, 3)));
                end
            end
        end

        check("sb_empty_at_end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
